game_end_ctrl: RTL and testbench

GAME_END_CTRL -- requirements
Module: game_end_ctrl

---
 rtl/game_end_ctrl_pkg.sv | 33 +++
 rtl/game_end_ctrl_if.sv | 11 +
 rtl/game_end_ctrl_timer.sv | 23 ++
 rtl/game_end_ctrl.sv | 170 +++++++++++++++++
 tb/tb_game_end_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_end_ctrl_pkg.sv
// Shared constants for the tank game result controller: FSM encodings, result codes,
// Avalon register addresses and CTRL bit positions.
package game_end_ctrl_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;
    localparam logic [1:0] ST_END     = 2'd3;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P1   = 2'b01,
        RES_P2   = 2'b10,
        RES_DRAW = 2'b11
    } result_t;

    localparam logic [1:0] ADDR_STATUS  = 2'd0;
    localparam logic [1:0] ADDR_CTRL    = 2'd1;
    localparam logic [1:0] ADDR_SCORE   = 2'd2;
    localparam logic [1:0] ADDR_HOLDOFF = 2'd3;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_ACK_BIT   = 1;
    localparam int CTRL_CLR_BIT   = 2;

    // bit2 carries either the state LSB or the irq flag, depending on the build.
    function automatic logic [31:0] status_word(input logic [1:0] state,
                                                input logic [1:0] result,
                                                input logic bit2);
        return {28'd0, state[1], bit2, result};
    endfunction

endpackage

// File: rtl/game_end_ctrl_if.sv
// Avalon-MM slave bus bundle between the CPU side and game_end_ctrl.
interface game_end_ctrl_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);
endinterface

// File: rtl/game_end_ctrl_timer.sv
// 16-bit holdoff down-counter: loads on request, counts down while enabled, stops at 0.
module game_end_ctrl_timer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        enable,
    output logic [15:0] count,
    output logic        zero
);

    always_ff @(posedge clk) begin
        if (!reset_n)
            count <= 16'd0;
        else if (load)
            count <= load_value;
        else if (enable && count != 16'd0)
            count <= count - 16'd1;
    end

    assign zero = (count == 16'd0);

endmodule

// File: rtl/game_end_ctrl.sv
// Tank game result controller with Avalon-MM register access.
// Optional feature: define GAME_END_CTRL_IRQ_EN to add the irq output (STATUS bit2 then reads irq).
module game_end_ctrl
    import game_end_ctrl_pkg::*;
#(
    parameter int HOLDOFF_RST = 16,
    parameter int SCORE_W     = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         hit_p1,
    input  logic         hit_p2,
    game_end_ctrl_if.slave bus,
    output logic [1:0]   game_end
`ifdef GAME_END_CTRL_IRQ_EN
    ,
    output logic         irq
`endif
);

    logic [1:0]         state;
    logic [1:0]         state_next;
    result_t            pending;
    result_t            end_result;
    logic               enter_end;
    logic               timer_load;
    logic [15:0]        timer_count;
    logic               timer_zero;
    logic [15:0]        holdoff_reg;
    logic [SCORE_W-1:0] score_p1;
    logic [SCORE_W-1:0] score_p2;
    logic [31:0]        score_word;
    logic               status_bit2;
    logic               ctrl_wr;
    logic               start;
    logic               ack;
    logic               clr_score;
    logic               opposite_hit;
    logic               unused_bus;

    assign ctrl_wr   = bus.write && (bus.address == ADDR_CTRL);
    assign start     = ctrl_wr && bus.writedata[CTRL_START_BIT];
    assign ack       = ctrl_wr && bus.writedata[CTRL_ACK_BIT];
    assign clr_score = ctrl_wr && bus.writedata[CTRL_CLR_BIT];
    assign unused_bus = ^{bus.read, bus.writedata[31:16]};

    // The already-destroyed tank cannot score again; only the survivor's hit makes a draw.
    assign opposite_hit = (pending == RES_P2) ? hit_p2 : hit_p1;

    game_end_ctrl_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (holdoff_reg),
        .enable     (state == ST_HOLDOFF),
        .count      (timer_count),
        .zero       (timer_zero)
    );

    always_comb begin
        state_next = state;
        end_result = RES_NONE;
        enter_end  = 1'b0;
        timer_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_next = ST_PLAY;
            end
            ST_PLAY: begin
                if (hit_p1 && hit_p2) begin
                    state_next = ST_END;
                    end_result = RES_DRAW;
                    enter_end  = 1'b1;
                end else if (hit_p1 || hit_p2) begin
                    if (holdoff_reg != 16'd0) begin
                        state_next = ST_HOLDOFF;
                        timer_load = 1'b1;
                    end else begin
                        state_next = ST_END;
                        end_result = hit_p1 ? RES_P2 : RES_P1;
                        enter_end  = 1'b1;
                    end
                end
            end
            ST_HOLDOFF: begin
                // Expiry is taken on the edge where the counter reaches zero.
                if (opposite_hit && !timer_zero) begin
                    state_next = ST_END;
                    end_result = RES_DRAW;
                    enter_end  = 1'b1;
                end else if (timer_count == 16'd1 || timer_zero) begin
                    state_next = ST_END;
                    end_result = pending;
                    enter_end  = 1'b1;
                end
            end
            ST_END: begin
                if (ack)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            game_end    <= RES_NONE;
            pending     <= RES_NONE;
            holdoff_reg <= 16'(HOLDOFF_RST);
            score_p1    <= '0;
            score_p2    <= '0;
        end else begin
            state <= state_next;
            if (timer_load)
                pending <= hit_p1 ? RES_P2 : RES_P1;
            if (enter_end)
                game_end <= end_result;
            else if (state_next != ST_END)
                game_end <= RES_NONE;
            if (bus.write && bus.address == ADDR_HOLDOFF)
                holdoff_reg <= bus.writedata[15:0];
            // A clear in the same cycle as a win discards that win.
            if (clr_score) begin
                score_p1 <= '0;
                score_p2 <= '0;
            end else if (enter_end) begin
                if (end_result == RES_P1 && score_p1 != '1)
                    score_p1 <= score_p1 + SCORE_W'(1);
                if (end_result == RES_P2 && score_p2 != '1)
                    score_p2 <= score_p2 + SCORE_W'(1);
            end
        end
    end

`ifdef GAME_END_CTRL_IRQ_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            irq <= 1'b0;
        else if (enter_end)
            irq <= 1'b1;
        else if (state == ST_END && ack)
            irq <= 1'b0;
    end
    assign status_bit2 = irq;
`else
    assign status_bit2 = state[0];
`endif

    always_comb begin
        score_word = '0;
        score_word[SCORE_W-1:0]     = score_p1;
        score_word[SCORE_W+15:16]   = score_p2;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            case (bus.address)
                ADDR_STATUS:  bus.readdata <= status_word(state, game_end, status_bit2);
                ADDR_SCORE:   bus.readdata <= score_word;
                ADDR_HOLDOFF: bus.readdata <= {16'd0, holdoff_reg};
                default:      bus.readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_game_end_ctrl.sv
// Self-checking bench for game_end_ctrl: vector table plus hand-written game sequences,
// register reads checked through a scoreboard queue.
module tb_game_end_ctrl;
    import game_end_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       hit_p1 = 1'b0;
    logic       hit_p2 = 1'b0;
    logic [1:0] game_end;
`ifdef GAME_END_CTRL_IRQ_EN
    logic       irq;
`endif

    game_end_ctrl_if bus_if();

    game_end_ctrl #(.HOLDOFF_RST(16), .SCORE_W(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .hit_p1   (hit_p1),
        .hit_p2   (hit_p2),
        .bus      (bus_if),
        .game_end (game_end)
`ifdef GAME_END_CTRL_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] value;
        string       name;
    } sb_entry_t;
    sb_entry_t sb_q[$];

    typedef struct {
        logic        h1;
        logic        h2;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [1:0]  ge;
        string       name;
    } vec_t;
    vec_t vecs[11];

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic h1, input logic h2, input logic wr,
                                  input logic [1:0] addr, input logic [31:0] data);
        hit_p1 = h1;
        hit_p2 = h2;
        bus_if.write = wr;
        bus_if.address = addr;
        bus_if.writedata = data;
        tick();
        hit_p1 = 1'b0;
        hit_p2 = 1'b0;
        bus_if.write = 1'b0;
        bus_if.writedata = 32'd0;
    endtask

    task automatic read_reg(input logic [1:0] addr, input logic [31:0] expected, input string name);
        sb_entry_t e;
        e.value = expected;
        e.name = name;
        sb_q.push_back(e);
        bus_if.address = addr;
        bus_if.read = 1'b1;
        tick();
        bus_if.read = 1'b0;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sb_q.pop_front();
            check_output(e.name, bus_if.readdata, e.value);
        end
    endtask

    task automatic wait_result(input int limit, output int cycles);
        cycles = 0;
        while (game_end == 2'b00 && cycles < limit) begin
            tick();
            cycles++;
        end
    endtask

    // Without irq, bit2 is the state LSB; with irq it mirrors "in END" (irq is held only there).
    function automatic logic [31:0] exp_status(input logic [1:0] st, input logic [1:0] ge);
`ifdef GAME_END_CTRL_IRQ_EN
        return {28'd0, st[1], (st == 2'd3), ge};
`else
        return {28'd0, st, ge};
`endif
    endfunction

    initial begin
        int cyc;
        bus_if.address = 2'd0;
        bus_if.read = 1'b0;
        bus_if.write = 1'b0;
        bus_if.writedata = 32'd0;

        vecs[0]  = '{1'b0, 1'b0, 1'b1, 2'd3, 32'd0, 2'b00, "holdoff_zero_write"};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 2'd1, 32'd1, 2'b00, "start_a"};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 2'b10, "p1_hit_immediate"};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 2'b10, "hit_in_end_ignored"};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 32'd1, 2'b10, "start_in_end_ignored"};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd1, 32'd2, 2'b00, "ack_a"};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 2'b00, "hit_in_idle_ignored"};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd1, 32'd2, 2'b00, "ack_in_idle_ignored"};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 2'd1, 32'd1, 2'b00, "start_b"};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 2'b01, "p2_hit_immediate"};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd1, 32'd2, 2'b00, "ack_b"};

        // Reset state
        tick();
        tick();
        check_output("reset_readdata", bus_if.readdata, 32'd0);
        check_output("reset_game_end", 32'(game_end), 32'd0);
`ifdef GAME_END_CTRL_IRQ_EN
        check_output("reset_irq", 32'(irq), 32'd0);
`endif
        reset_n = 1'b1;
        read_reg(ADDR_HOLDOFF, 32'd16, "reset_holdoff");
        read_reg(ADDR_STATUS, exp_status(ST_IDLE, 2'b00), "reset_status");
        read_reg(ADDR_SCORE, 32'd0, "reset_score");
        read_reg(ADDR_CTRL, 32'd0, "ctrl_reads_zero");

        // Single hit with 16-cycle holdoff -> P1 wins
        $display("[TB] holdoff win sequence");
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd1);
        read_reg(ADDR_STATUS, exp_status(ST_PLAY, 2'b00), "play_status");
        apply_stimulus(1'b0, 1'b1, 1'b0, ADDR_STATUS, 32'd0);
        read_reg(ADDR_STATUS, exp_status(ST_HOLDOFF, 2'b00), "holdoff_status");
        wait_result(40, cyc);
        check_output("holdoff_length", 32'(cyc + 1), 32'd16);
        check_output("holdoff_winner", 32'(game_end), 32'b01);
`ifdef GAME_END_CTRL_IRQ_EN
        check_output("irq_on_end", 32'(irq), 32'd1);
`endif
        read_reg(ADDR_STATUS, exp_status(ST_END, 2'b01), "end_status");
        read_reg(ADDR_SCORE, 32'h0000_0001, "score_after_p1_win");
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd2);
        check_output("ack_clears_result", 32'(game_end), 32'd0);
`ifdef GAME_END_CTRL_IRQ_EN
        check_output("irq_cleared_by_ack", 32'(irq), 32'd0);
`endif

        // Simultaneous hits in PLAY -> draw
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd1);
        apply_stimulus(1'b1, 1'b1, 1'b0, ADDR_STATUS, 32'd0);
        check_output("simultaneous_draw", 32'(game_end), 32'b11);
        read_reg(ADDR_SCORE, 32'h0000_0001, "score_after_draw");
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd2);

        // Opposite hit 5 cycles into holdoff -> draw; repeat hit ignored
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, ADDR_STATUS, 32'd0);
        tick();
        apply_stimulus(1'b1, 1'b0, 1'b0, ADDR_STATUS, 32'd0);
        check_output("repeat_hit_ignored", 32'(game_end), 32'd0);
        tick();
        tick();
        apply_stimulus(1'b0, 1'b1, 1'b0, ADDR_STATUS, 32'd0);
        check_output("holdoff_draw", 32'(game_end), 32'b11);
        read_reg(ADDR_SCORE, 32'h0000_0001, "score_after_holdoff_draw");
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd2);
        check_output("ack_after_draw", 32'(game_end), 32'd0);
        read_reg(ADDR_STATUS, exp_status(ST_IDLE, 2'b00), "idle_after_ack");

        // Table-driven vectors with HOLDOFF = 0
        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].h1, vecs[i].h2, vecs[i].wr, vecs[i].addr, vecs[i].data);
            check_output(vecs[i].name, 32'(game_end), 32'(vecs[i].ge));
        end
        read_reg(ADDR_SCORE, 32'h0001_0002, "score_after_table");

        // Clear coincident with a win: clear wins
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b1, ADDR_CTRL, 32'd4);
        check_output("clear_with_win_result", 32'(game_end), 32'b10);
        read_reg(ADDR_SCORE, 32'd0, "clear_beats_increment");
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd2);

        // 256 P2 wins saturate at 255
        $display("[TB] saturation sequence");
        for (int i = 0; i < 256; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd1);
            apply_stimulus(1'b1, 1'b0, 1'b0, ADDR_STATUS, 32'd0);
            apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd2);
        end
        read_reg(ADDR_SCORE, 32'h00FF_0000, "p2_saturated");

        // HOLDOFF rewrite during a countdown only affects the next load
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_HOLDOFF, 32'd10);
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd1);
        apply_stimulus(1'b0, 1'b1, 1'b0, ADDR_STATUS, 32'd0);
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_HOLDOFF, 32'd3);
        wait_result(40, cyc);
        check_output("countdown_unaffected", 32'(cyc + 1), 32'd10);
        check_output("countdown_winner", 32'(game_end), 32'b01);
        read_reg(ADDR_SCORE, 32'h00FF_0001, "score_after_countdown");
        read_reg(ADDR_HOLDOFF, 32'd3, "holdoff_readback");
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd1);
        read_reg(ADDR_STATUS, exp_status(ST_END, 2'b01), "start_in_end_stays_end");

        // Reset in the middle of a holdoff
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd2);
        apply_stimulus(1'b0, 1'b0, 1'b1, ADDR_CTRL, 32'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, ADDR_STATUS, 32'd0);
        tick();
        reset_n = 1'b0;
        tick();
        check_output("midgame_reset_readdata", bus_if.readdata, 32'd0);
        check_output("midgame_reset_game_end", 32'(game_end), 32'd0);
        reset_n = 1'b1;
        read_reg(ADDR_STATUS, exp_status(ST_IDLE, 2'b00), "midgame_reset_status");
        read_reg(ADDR_SCORE, 32'd0, "midgame_reset_score");
        read_reg(ADDR_HOLDOFF, 32'd16, "midgame_reset_holdoff");
        check_output("no_late_result", 32'(game_end), 32'd0);

        // Hits in IDLE do nothing
        apply_stimulus(1'b1, 1'b0, 1'b0, ADDR_STATUS, 32'd0);
        apply_stimulus(1'b0, 1'b1, 1'b0, ADDR_STATUS, 32'd0);
        apply_stimulus(1'b1, 1'b1, 1'b0, ADDR_STATUS, 32'd0);
        check_output("idle_hits_game_end", 32'(game_end), 32'd0);
        read_reg(ADDR_STATUS, exp_status(ST_IDLE, 2'b00), "idle_hits_status");
        read_reg(ADDR_SCORE, 32'd0, "idle_hits_score");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
